// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order, digit patterns (active-high) and special codes.
// Pure constants, no latency, no flow control.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] BIT_A = 7'(1) << SEG_A;
  localparam logic [6:0] BIT_B = 7'(1) << SEG_B;
  localparam logic [6:0] BIT_C = 7'(1) << SEG_C;
  localparam logic [6:0] BIT_D = 7'(1) << SEG_D;
  localparam logic [6:0] BIT_E = 7'(1) << SEG_E;
  localparam logic [6:0] BIT_F = 7'(1) << SEG_F;
  localparam logic [6:0] BIT_G = 7'(1) << SEG_G;

  localparam logic [6:0] SEG_0     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F;
  localparam logic [6:0] SEG_1     = BIT_B | BIT_C;
  localparam logic [6:0] SEG_2     = BIT_A | BIT_B | BIT_D | BIT_E | BIT_G;
  localparam logic [6:0] SEG_3     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_G;
  localparam logic [6:0] SEG_4     = BIT_B | BIT_C | BIT_F | BIT_G;
  localparam logic [6:0] SEG_5     = BIT_A | BIT_C | BIT_D | BIT_F | BIT_G;
  localparam logic [6:0] SEG_6     = BIT_A | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] SEG_7     = BIT_A | BIT_B | BIT_C;
  localparam logic [6:0] SEG_8     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_E | BIT_F | BIT_G;
  localparam logic [6:0] SEG_9     = BIT_A | BIT_B | BIT_C | BIT_D | BIT_F | BIT_G;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_BAD   = 4'hE;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_ONE,
    SEL_MULTI
  } sel_cls_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Scan-side bundle between a multiplexed display driver (master) and the scan decoder (slave).
// No handshake: the scan is free-running and the decoder never stalls it.
interface seg_scan_decoder_if #(
  parameter int N_DIGITS = 8
);
  logic [6:0]            seg_out;
  logic [N_DIGITS-1:0]   seg_select;
  logic                  err_clr;
  logic [4*N_DIGITS-1:0] digits;
  logic                  frame_tick;
  logic                  frame_valid;
  logic                  err_pattern;
  logic                  err_select;

  modport master (
    output seg_out, seg_select, err_clr,
    input  digits, frame_tick, frame_valid, err_pattern, err_select
  );

  modport slave (
    input  seg_out, seg_select, err_clr,
    output digits, frame_tick, frame_valid, err_pattern, err_select
  );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// Active-high 7-segment pattern to BCD code (blank -> F, unknown -> E with o_bad).
// Combinational, zero latency, no backpressure.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_bad
);

  always_comb begin
    o_code = CODE_BAD;
    o_bad  = 1'b0;
    case (i_seg)
      SEG_0:     o_code = 4'd0;
      SEG_1:     o_code = 4'd1;
      SEG_2:     o_code = 4'd2;
      SEG_3:     o_code = 4'd3;
      SEG_4:     o_code = 4'd4;
      SEG_5:     o_code = 4'd5;
      SEG_6:     o_code = 4'd6;
      SEG_7:     o_code = 4'd7;
      SEG_8:     o_code = 4'd8;
      SEG_9:     o_code = 4'd9;
      SEG_BLANK: o_code = CODE_BLANK;
      default:   o_bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds N_DIGITS BCD digits from a multiplexed 7-seg scan; frame_tick 1 cycle after the completing sample.
// Passive monitor: never backpressures the scan, incomplete frames wait indefinitely.
module seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 8,
  parameter int SETTLE         = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic               CLK,
  input  logic               CLR,
  seg_scan_decoder_if.slave  bus
);

  localparam int         K_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [6:0]          w_seg;
  logic [N_DIGITS-1:0] w_sel;
  sel_cls_t            w_cls;
  logic [K_W-1:0]      w_k;
  logic                w_new_dwell;
  logic [3:0]          w_cnt_base;
  logic [3:0]          w_cnt_nxt;
  logic                w_sample;
  logic [3:0]          w_code;
  logic                w_bad;
  logic                w_complete;

  sel_cls_t                 r_prev_cls;
  logic [K_W-1:0]           r_prev_k;
  logic [3:0]               r_cnt;
  logic [N_DIGITS-1:0][3:0] r_shadow;
  logic [N_DIGITS-1:0][3:0] r_digits;
  logic [N_DIGITS-1:0]      r_seen;
  logic                     r_frame_valid;
  logic                     r_err_pattern;
  logic                     r_err_select;

  assign w_seg = bus.seg_out ^ {7{SEG_ACTIVE_LOW}};
  assign w_sel = bus.seg_select ^ {N_DIGITS{SEL_ACTIVE_LOW}};

  always_comb begin
    w_cls = SEL_IDLE;
    w_k   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w_sel[i]) w_k = K_W'(i);
    end
    if (w_sel == '0)                                     w_cls = SEL_IDLE;
    else if ((w_sel & (w_sel - N_DIGITS'(1))) == '0)     w_cls = SEL_ONE;
    else                                                 w_cls = SEL_MULTI;
  end

  // The first cycle of a dwell counts as stable cycle 1, so SETTLE=1 samples immediately.
  always_comb begin
    w_new_dwell = (r_prev_cls != SEL_ONE) || (w_k != r_prev_k);
    w_cnt_base  = w_new_dwell ? 4'd0 : r_cnt;
    w_sample    = (w_cls == SEL_ONE) && (w_cnt_base == SETTLE_C - 4'd1);
    w_cnt_nxt   = 4'd0;
    if (w_cls == SEL_ONE) begin
      w_cnt_nxt = (w_cnt_base == SETTLE_C) ? w_cnt_base : w_cnt_base + 4'd1;
    end
  end

  seg7_pattern_decoder u_dec (
    .i_seg  (w_seg),
    .o_code (w_code),
    .o_bad  (w_bad)
  );

  assign w_complete = &r_seen;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_prev_cls    <= SEL_IDLE;
      r_prev_k      <= '0;
      r_cnt         <= 4'd0;
      r_shadow      <= '0;
      r_digits      <= '1;
      r_seen        <= '0;
      r_frame_valid <= 1'b0;
      r_err_pattern <= 1'b0;
      r_err_select  <= 1'b0;
    end else begin
      r_prev_cls <= w_cls;
      r_prev_k   <= w_k;
      r_cnt      <= w_cnt_nxt;
      if (w_sample) r_shadow[w_k] <= w_code;
      // A sample landing on the completion cycle already belongs to the next frame.
      r_seen <= (w_complete ? '0 : r_seen) | (w_sample ? w_sel : '0);
      if (w_complete) begin
        r_digits      <= r_shadow;
        r_frame_valid <= 1'b1;
      end
      if (w_sample && w_bad)     r_err_pattern <= 1'b1;
      else if (bus.err_clr)      r_err_pattern <= 1'b0;
      if (w_cls == SEL_MULTI)    r_err_select  <= 1'b1;
      else if (bus.err_clr)      r_err_select  <= 1'b0;
    end
  end

  assign bus.digits      = r_digits;
  assign bus.frame_tick  = w_complete;
  assign bus.frame_valid = r_frame_valid;
  assign bus.err_pattern = r_err_pattern;
  assign bus.err_select  = r_err_select;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receiving end of the multiplexed 7-segment display interface (seg_out / seg_select) driven by the chess-clock top.
- Watches the scan and reconstructs the 8 displayed digits as BCD codes, with frame-complete and error reporting.
- Used as a self-checking monitor in synthesis benches.
- Synthesizable, so it can also sit in a loopback/diagnostic path on the board.

Parameters:
- N_DIGITS, 8: number of scanned digits; equals the seg_select width.
- SETTLE, 2: consecutive cycles a select must be stable before its segments are sampled; range 1..15.
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when its seg_out bit is 0.
- SEL_ACTIVE_LOW, 1: 1 means a digit is selected when its seg_select bit is 0.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- seg_out  in  7  segment lines; bit0=a ... bit6=g.
- seg_select  in  N_DIGITS  digit enables; bit i = digit i.
- err_clr  in  1  synchronous clear of the sticky error flags.
- digits  out  4*N_DIGITS  decoded codes; digit i is at [4i+3:4i].
- frame_tick  out  1  one-cycle pulse when digits is updated.
- frame_valid  out  1  set on the first completed frame; cleared only by CLR.
- err_pattern  out  1  sticky: an unrecognised segment pattern was sampled.
- err_select  out  1  sticky: more than one select was active at once.

Behaviour:
- Reset (CLR=1, async):
  - digits = all 4'hF.
  - frame_tick, frame_valid, err_pattern, err_select = 0.
  - Shadow digit registers, seen mask and settle counter cleared.
  - CLR asserted mid-frame discards the partial frame.
- Input normalisation: XOR seg_out / seg_select with their polarity parameters to get active-high seg and sel.
- sel classification, each cycle:
  - Zero bits set: idle. Settle counter held at 0; no sample.
  - Exactly one bit set: index k is encoded.
  - Two or more bits set: err_select <= 1; settle counter reset to 0; no sample.
- Settle counter (4 bit):
  - Resets to 0 whenever k differs from the previous cycle's k, or the previous cycle was not one-hot.
  - Increments while k is stable, saturating at SETTLE.
  - Sample strobe fires in the cycle the counter transitions to SETTLE-1 → SETTLE, i.e. the SETTLE-th stable cycle. Exactly one sample per dwell.
- Pattern decode (active-high seg → code):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x00→4'hF (blank).
  - Anything else → 4'hE, and err_pattern <= 1.
- On a sample: shadow[k] <= code; seen[k] <= 1.
  - A repeated sample of an already-seen digit overwrites shadow[k]; the latest value wins.
- Frame completion, in the cycle after seen becomes all ones:
  - digits <= shadow, all digits at once.
  - frame_tick = 1 for exactly one cycle; frame_valid <= 1; seen <= 0.
  - If a sample lands in that same cycle, it is recorded into the new frame's seen/shadow.
- Latency: sample strobe to frame_tick is 1 cycle when the sample completes the set.
- Sticky errors:
  - Cleared by err_clr=1.
  - If err_clr and a new error event occur in the same cycle, the error wins (flag stays 1).
- Idle gaps and partial scans never time out; an incomplete frame simply waits.

Decomposition:
- Shared package seg7_pkg:
  - Segment pattern constants SEG_0..SEG_9 and SEG_BLANK.
  - CODE_BLANK=4'hF and CODE_BAD=4'hE.
  - Segment bit-order constants (a=0 ... g=6).
- One combinational sub-module, seg7_pattern_decoder: 7-bit active-high pattern → 4-bit code plus bad flag. It is reusable by any future display logic.
- The scan FSM, settle counter, shadow and seen registers live in seg_scan_decoder itself.

Test Plan:
- Reset check: CLR=1 mid-run → digits=32'hFFFFFFFF, all flags 0 immediately, before the next CLK edge.
- Full frame: scan selects 0..7 (active-low 8'hFE, 8'hFD, ...), 4 cycles each, seg_out=~SEG_d for digits 1,2,3,4,5,6,7,8 → one frame_tick; digits=32'h87654321; frame_valid=1; errors 0.
- Settle: select held only 1 cycle with SETTLE=2 → no sample; then held 2 cycles → sample on the 2nd cycle. Held 10 cycles → exactly one sample.
- Bad pattern: digit 3 shows 0x77 ("A") → err_pattern=1; digit 3 of the next frame = 4'hE. err_clr pulse with no new error → err_pattern=0.
- Select collision: seg_select=8'hFC (two active) → err_select=1, no sample for either digit. err_clr together with a further collision → err_select stays 1.
- Blank and overwrite: digit 0 all segments off → code 4'hF. Digit 2 scanned twice within one frame (showing 5, then 9) → digits[11:8]=4'h9.
